// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op and state encodings shared by the multiply/divide sequencer
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - request/result bundle between the execute stage and the sequencer
interface mdu_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] In_A;
  logic [DATA_WIDTH-1:0] In_B;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;

  modport master (output Start, Op, In_A, In_B, input Busy, Done, Hi, Lo);
  modport slave  (input Start, Op, In_A, In_B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/adder.sv
// rtl/adder.sv - plain ripple-style adder shared by every sequencer iteration
module Adder #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum
);

  assign Sum = A + B;

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative shift-add multiply / restoring divide producing HI/LO
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RST,
  mdu_sequencer_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  state_t          r_state;
  logic            r_is_div;
  logic [W:0]      r_addend;
  logic [W-1:0]    r_hi_acc;
  logic [W-1:0]    r_lo_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_signed;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [W:0]      w_shift_rem;
  logic [W:0]      w_add_a;
  logic [W:0]      w_add_b;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_prod;

  assign w_signed = op_is_signed(bus.Op);
  assign w_a_mag  = (w_signed && bus.In_A[W-1]) ? -bus.In_A : bus.In_A;
  assign w_b_mag  = (w_signed && bus.In_B[W-1]) ? -bus.In_B : bus.In_B;

  // Divide feeds {rem, quo msb} against the pre-negated divisor; multiply feeds the upper word.
  assign w_shift_rem = {r_hi_acc, r_lo_acc[W-1]};
  assign w_add_a     = r_is_div ? w_shift_rem : {1'b0, r_hi_acc};
  assign w_add_b     = (r_is_div || r_lo_acc[0]) ? r_addend : '0;
  assign w_prod      = {r_hi_acc, r_lo_acc};

  Adder #(.WIDTH(W + 1)) u_adder (
    .A   (w_add_a),
    .B   (w_add_b),
    .Sum (w_sum)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_is_div <= 1'b0;
      r_addend <= '0;
      r_hi_acc <= '0;
      r_lo_acc <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.Start) begin
            r_is_div <= op_is_div(bus.Op);
            // Divisor is held as its two's complement so each step is a single add.
            r_addend <= op_is_div(bus.Op) ? (~{1'b0, w_b_mag} + {{W{1'b0}}, 1'b1})
                                          : {1'b0, w_a_mag};
            r_lo_acc <= op_is_div(bus.Op) ? w_a_mag : w_b_mag;
            r_hi_acc <= '0;
            r_cnt    <= '0;
            r_neg_q  <= w_signed & (bus.In_A[W-1] ^ bus.In_B[W-1]);
            r_neg_r  <= w_signed & bus.In_A[W-1];
            r_div0   <= op_is_div(bus.Op) && (bus.In_B == '0);
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (r_is_div) begin
            r_hi_acc <= w_sum[W] ? w_shift_rem[W-1:0] : w_sum[W-1:0];
            r_lo_acc <= {r_lo_acc[W-2:0], ~w_sum[W]};
          end else begin
            r_hi_acc <= w_sum[W:1];
            r_lo_acc <= {w_sum[0], r_lo_acc[W-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_q ? -w_prod : w_prod;
          end else begin
            // Divide by zero leaves |A| as remainder, so the remainder sign restores raw A.
            r_lo <= (r_neg_q && !r_div0) ? -r_lo_acc : r_lo_acc;
            r_hi <= r_neg_r ? -r_hi_acc : r_hi_acc;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer_if #(.DATA_WIDTH(32)) mif ();

  mdu_sequencer #(.DATA_WIDTH(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (mif)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; issues Start there, then checks latency, busy length and result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int glitch);
    int n;
    int busy_cnt;
    mif.Start = 1'b1;
    mif.Op    = op;
    mif.In_A  = a;
    mif.In_B  = b;
    @(negedge clk);
    mif.Start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (mif.Done !== 1'b1 && n < 60) begin
      if (mif.Busy === 1'b1) busy_cnt++;
      if (n == glitch) begin
        mif.Start = 1'b1;
        mif.Op    = ~op;
        mif.In_A  = ~a;
        mif.In_B  = b + 32'd3;
      end else begin
        mif.Start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    mif.Start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_hi"}, 64'(mif.Hi), 64'(eh));
    chk({tag, "_lo"}, 64'(mif.Lo), 64'(el));
  endtask

  initial begin
    int dcount;
    rst      = 1'b1;
    mif.Start = 1'b0;
    mif.Op    = OP_MULT;
    mif.In_A  = '0;
    mif.In_B  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ctl", 64'({mif.Busy, mif.Done}), 64'd0);
      chk("idle_data", {mif.Hi, mif.Lo}, 64'd0);
    end

    @(negedge clk);
    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    @(negedge clk);
    do_op("mult_neg", OP_MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
    @(negedge clk);
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    do_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    @(negedge clk);
    do_op("mult_min", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    @(negedge clk);
    do_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    do_op("divu_glitch", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 10);
    do_op("b2b_multu", OP_MULTU, 32'h1234_5678, 32'h10, 32'h0000_0001, 32'h2345_6780, 0);

    @(negedge clk);
    mif.Start = 1'b1;
    mif.Op    = OP_DIVU;
    mif.In_A  = 32'h0000_FFFF;
    mif.In_B  = 32'd3;
    @(negedge clk);
    mif.Start = 1'b0;
    repeat (9) @(negedge clk);
    chk("calc_busy", 64'(mif.Busy), 64'd1);
    chk("calc_hold", {mif.Hi, mif.Lo}, 64'h0000_0001_2345_6780);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ctl", 64'({mif.Busy, mif.Done}), 64'd0);
    chk("rst_data", {mif.Hi, mif.Lo}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.Done === 1'b1 || mif.Busy === 1'b1) dcount++;
    end
    chk("rst_no_done", 64'(dcount), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer producing the HI/LO pair for MULT, MULTU, DIV and DIVU. It drives a single shared Adder datapath for DATA_WIDTH iterations per operation:

- shift-add for multiply;
- restoring subtract for divide.

It sits beside the ALU in the execute stage. The core stalls on `Busy` and latches `Hi`/`Lo` into the HI/LO registers when `Done` pulses.

## Interface

Parameters:
- `DATA_WIDTH`, 32, operand width; `Hi`/`Lo` are each this width.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `Op`  in  2  operation, sampled with `Start`: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `In_A`  in  DATA_WIDTH  multiplicand / dividend, sampled with `Start`.
- `In_B`  in  DATA_WIDTH  multiplier / divisor, sampled with `Start`.
- `Busy`  out  1  operation in progress (CALC, FIX).
- `Done`  out  1  one-cycle pulse; `Hi`/`Lo` valid from this cycle.
- `Hi`  out  DATA_WIDTH  product upper word / remainder.
- `Lo`  out  DATA_WIDTH  product lower word / quotient.

## Operation

States are IDLE, CALC, FIX and DONE.

- **IDLE / DONE, `Start`=1:**
  - Capture `Op` and the operand magnitudes. Signed ops negate negative operands; unsigned ops use the raw operands.
  - Capture result signs:
    - product/quotient sign = A[msb] XOR B[msb];
    - remainder sign = A[msb].
  - Clear the accumulators and the iteration counter, then go to CALC.
- **IDLE / DONE, `Start`=0:** go to (or stay in) IDLE.
- **CALC (multiply):**
  - Each cycle, if multiplier LSB = 1, add the multiplicand into the upper accumulator through the Adder (DATA_WIDTH+1 bits, carry kept).
  - Then shift {carry, upper, lower} right by 1.
- **CALC (divide):**
  - Each cycle, shift {rem, quo} left by 1 and compute rem − divisor through the Adder (adding the one's complement of the divisor plus a constant 1 held in the captured operand).
  - If the result is non-negative, rem = result and quo LSB = 1; otherwise restore.
- **CALC exit:** after exactly DATA_WIDTH iterations (counter DATA_WIDTH−1 → 0 wrap), go to FIX.
- **FIX:**
  - Signed ops apply the captured signs: negate the 2W product, the quotient and/or the remainder as flagged.
  - Write `Hi`/`Lo`, then go to DONE.
- **Divide by zero** (divisor = 0, DIV or DIVU):
  - The sequence still runs the full length; `Lo` = all ones and `Hi` = `In_A` as captured (raw, no sign fix).
  - FIX bypasses correction for this case.
- **Overflow case DIV −2^(W−1) / −1:** `Lo` = 0x80000000 and `Hi` = 0 (for W=32). This is not an error; no flag.
- **`Start` while `Busy`=1:** ignored; `Op`/`In_A`/`In_B` are not sampled.
- **`Hi`/`Lo` hold:** they keep the last result until the next FIX write; they do not change during CALC.

## Timing

- **Reset values:** state IDLE; `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0; counter and accumulators 0.
- **Reset in any state:** RST wins over all other inputs; the in-flight operation is discarded and no `Done` is produced.
- **Latency from the accepting edge E:**
  - `Busy`=1 during cycles E+1 … E+DATA_WIDTH+1 (CALC ×W, FIX ×1).
  - `Done`=1 during cycle E+DATA_WIDTH+2 only, with `Hi`/`Lo` valid.
  - For W=32: `Done` arrives 34 cycles after `Start` is sampled.
- **Back-to-back:** `Start` asserted in the DONE cycle is accepted. `Done` still pulses for that cycle, and `Busy` rises the next cycle, with no idle bubble.
- **Registered outputs:** `Busy` and `Done` are decoded from the registered state only, with no combinational path from `Start`.

## Structure

- **Shared package `mdu_pkg`:**
  - op encodings `OP_MULT`=2'b00, `OP_MULTU`=2'b01, `OP_DIV`=2'b10, `OP_DIVU`=2'b11;
  - state encoding (IDLE, CALC, FIX, DONE).
- **Sub-module:** one instance of the existing `Adder` with `DATA_WIDTH`+1 width. It is the only iteration arithmetic resource.
- **Sign correction:** the sign pre-/post-negators are local logic in `mdu_sequencer`; they are not a separate module.
- **Counter:** $clog2(`DATA_WIDTH`) bits, local.

## Test plan

1. **Reset, then idle.** Hold RST 2 cycles, then `Start`=0 for 5 cycles → `Busy`=0, `Done`=0, `Hi`=`Lo`=0 throughout.
2. **MULTU.** A=0xFFFFFFFF, B=0xFFFFFFFF → `Done` exactly 34 cycles after accept; `Hi`=0xFFFFFFFE, `Lo`=0x00000001.
3. **MULT.** A=−7 (0xFFFFFFF9), B=6 → `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFD6. Then DIV −7/2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF.
4. **DIVU by zero.** A=0x1234, B=0 → `Lo`=0xFFFFFFFF, `Hi`=0x00001234, normal 34-cycle latency. Then DIV 0x80000000 / 0xFFFFFFFF → `Lo`=0x80000000, `Hi`=0.
5. **`Start` while busy, then back-to-back.**
   - Pulse `Start` with different operands mid-CALC → ignored; the result equals the first op.
   - Assert `Start` in the DONE cycle → accepted; second `Done` arrives 34 cycles later.
6. **Reset mid-operation.** Assert RST at iteration 10 of DIVU → next cycle IDLE, `Busy`=0, `Hi`/`Lo`=0, and no `Done` pulse within the following 40 cycles.
